turf_aurora_link_watchdog: RTL and testbench

- Init_clk-domain supervisor for the TURFIO Aurora link.
- Monitors link status (channel_up, lane_up, hard/soft errors) and issues reset requests to the Aurora reset sequencer's reset input.
- The sequencer rising-edge detects that input, so requests are clean multi-cycle high pulses.
- Also provides link-health status and saturating statistics counters for register readout.

---
 rtl/turf_aurora_link_watchdog.sv | 140 ++++++++++++++
 tb/tb_turf_aurora_link_watchdog.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_aurora_link_watchdog.sv
// Init-clock supervisor for the TURFIO Aurora link: watches channel/lane status and errors,
// issues clean multi-cycle reset requests to the Aurora reset sequencer, and keeps link statistics.
module turf_aurora_link_watchdog #(
    parameter logic [31:0] UP_TIMEOUT      = 32'h0800_0000,
    parameter int unsigned DEBOUNCE        = 16,
    parameter int unsigned REQ_LEN         = 16,
    parameter int unsigned HOLDOFF_LEN     = 256,
    parameter int unsigned SOFT_ERR_WINDOW = 1048576,
    parameter int unsigned SOFT_ERR_LIMIT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        force_reset_i,
    input  logic        channel_up_i,
    input  logic        lane_up_i,
    input  logic        hard_err_i,
    input  logic        soft_err_i,
    output logic        reset_req_o,
    output logic        link_ok_o,
    output logic [1:0]  state_o,
    output logic [7:0]  reset_count_o,
    output logic [15:0] soft_err_count_o
);

    typedef enum logic [1:0] {
        ST_WAIT_UP = 2'd0,
        ST_UP      = 2'd1,
        ST_REQ     = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned WIN_W  = $clog2(SOFT_ERR_WINDOW + 1);
    localparam int unsigned WERR_W = $clog2(SOFT_ERR_LIMIT + 1);

    localparam logic [DEB_W-1:0]  DEB_DONE   = DEB_W'(DEBOUNCE);
    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(SOFT_ERR_WINDOW - 1);
    localparam logic [WERR_W-1:0] WERR_LIMIT = WERR_W'(SOFT_ERR_LIMIT);
    localparam logic [31:0]       REQ_LAST   = 32'(REQ_LEN - 1);
    localparam logic [31:0]       HOLD_LAST  = 32'(HOLDOFF_LEN - 1);

    state_t              state_q, state_d;
    logic [31:0]         timer_q, timer_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [WERR_W-1:0]   werr_q, werr_d;
    logic [7:0]          reset_cnt_q, reset_cnt_d;
    logic [15:0]         soft_cnt_q, soft_cnt_d;
    logic                reset_req_q, reset_req_d;
    logic                link_ok_q, link_ok_d;
    logic                win_wrap;
    logic                link_bad;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 32'd1;
        deb_d       = '0;
        win_d       = '0;
        werr_d      = '0;
        reset_cnt_d = reset_cnt_q;
        soft_cnt_d  = soft_cnt_q;
        win_wrap    = 1'b0;
        link_bad    = 1'b0;

        case (state_q)
            ST_WAIT_UP: begin
                timer_d = (timer_q == UP_TIMEOUT) ? timer_q : timer_q + 32'd1;
                deb_d   = (channel_up_i && lane_up_i) ? deb_q + DEB_W'(1) : '0;
                // A link that finishes debouncing wins over a coincident timeout.
                if (force_reset_i)                          state_d = ST_REQ;
                else if (deb_d == DEB_DONE)                 state_d = ST_UP;
                else if (timer_d == UP_TIMEOUT && enable_i) state_d = ST_REQ;
            end
            ST_UP: begin
                // An error on the wrap cycle is counted into the window that starts next.
                win_wrap = (win_q == WIN_LAST);
                win_d    = win_wrap ? '0 : win_q + WIN_W'(1);
                werr_d   = win_wrap ? '0 : werr_q;
                if (soft_err_i) begin
                    if (werr_d != WERR_LIMIT) werr_d = werr_d + WERR_W'(1);
                    if (soft_cnt_q != '1)     soft_cnt_d = soft_cnt_q + 16'd1;
                end
                link_bad = !channel_up_i || !lane_up_i || hard_err_i;
                if (force_reset_i)                            state_d = ST_REQ;
                else if (link_bad)                            state_d = enable_i ? ST_REQ : ST_WAIT_UP;
                else if (werr_d == WERR_LIMIT && enable_i)    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (timer_q == REQ_LAST) state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (force_reset_i)            state_d = ST_REQ;
                else if (timer_q == HOLD_LAST) state_d = ST_WAIT_UP;
            end
            default: state_d = ST_WAIT_UP;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
            deb_d   = '0;
        end
        if (state_d == ST_REQ && state_q != ST_REQ && reset_cnt_q != '1)
            reset_cnt_d = reset_cnt_q + 8'd1;

        reset_req_d = (state_d == ST_REQ);
        link_ok_d   = (state_d == ST_UP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_WAIT_UP;
            timer_q     <= '0;
            deb_q       <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            reset_cnt_q <= '0;
            soft_cnt_q  <= '0;
            reset_req_q <= 1'b0;
            link_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            deb_q       <= deb_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            reset_cnt_q <= reset_cnt_d;
            soft_cnt_q  <= soft_cnt_d;
            reset_req_q <= reset_req_d;
            link_ok_q   <= link_ok_d;
        end
    end

    assign reset_req_o      = reset_req_q;
    assign link_ok_o        = link_ok_q;
    assign state_o          = state_q;
    assign reset_count_o    = reset_cnt_q;
    assign soft_err_count_o = soft_cnt_q;

endmodule

// File: tb/tb_turf_aurora_link_watchdog.sv
// Bench for turf_aurora_link_watchdog: directed scenarios plus random traffic, every cycle checked
// against a time-since-entry reference model.
module tb_turf_aurora_link_watchdog;

    localparam logic [31:0] P_UP_TIMEOUT = 32'd100;
    localparam int P_DEB  = 16;
    localparam int P_REQ  = 16;
    localparam int P_HOLD = 256;
    localparam int P_WIN  = 1000;
    localparam int P_LIM  = 4;

    localparam int S_WAIT = 0;
    localparam int S_UP   = 1;
    localparam int S_REQ  = 2;
    localparam int S_HOLD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, frc, cu, lu, he, se;
    logic        req, ok;
    logic [1:0]  st;
    logic [7:0]  rc;
    logic [15:0] sec;

    turf_aurora_link_watchdog #(
        .UP_TIMEOUT     (P_UP_TIMEOUT),
        .DEBOUNCE       (P_DEB),
        .REQ_LEN        (P_REQ),
        .HOLDOFF_LEN    (P_HOLD),
        .SOFT_ERR_WINDOW(P_WIN),
        .SOFT_ERR_LIMIT (P_LIM)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (en),
        .force_reset_i   (frc),
        .channel_up_i    (cu),
        .lane_up_i       (lu),
        .hard_err_i      (he),
        .soft_err_i      (se),
        .reset_req_o     (req),
        .link_ok_o       (ok),
        .state_o         (st),
        .reset_count_o   (rc),
        .soft_err_count_o(sec)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: tracks which state we are in, when it was entered, and derives
    // every decision from elapsed cycles.
    longint cyc = 0;
    longint m_entry = 0;
    longint m_last_low = 0;
    longint m_widx = 0;
    int     m_state = S_WAIT;
    int     m_werr = 0;
    int     m_rc = 0;
    int     m_sec = 0;

    task automatic model_step();
        int nxt;
        longint cin, run, k, idx, base;
        if (rst) begin
            m_state = S_WAIT; m_entry = cyc + 1;
            m_rc = 0; m_sec = 0; m_werr = 0; m_widx = 0;
        end else begin
            nxt = m_state;
            cin = cyc - m_entry + 1;
            case (m_state)
                S_WAIT: begin
                    if (!(cu && lu)) m_last_low = cyc;
                    base = (m_last_low > m_entry - 1) ? m_last_low : m_entry - 1;
                    run  = cyc - base;
                    if (frc)                              nxt = S_REQ;
                    else if (run >= P_DEB)                nxt = S_UP;
                    else if (cin >= P_UP_TIMEOUT && en)   nxt = S_REQ;
                end
                S_UP: begin
                    k   = cyc - m_entry;
                    idx = (k + 1) / P_WIN;
                    if (idx != m_widx) begin m_widx = idx; m_werr = 0; end
                    if (se) begin
                        m_werr++;
                        if (m_sec < 65535) m_sec++;
                    end
                    if (frc)                        nxt = S_REQ;
                    else if (!cu || !lu || he)      nxt = en ? S_REQ : S_WAIT;
                    else if (m_werr >= P_LIM && en) nxt = S_REQ;
                end
                S_REQ:  if (cin == P_REQ) nxt = S_HOLD;
                default: begin
                    if (frc)                nxt = S_REQ;
                    else if (cin == P_HOLD) nxt = S_WAIT;
                end
            endcase
            if (nxt != m_state) begin
                m_entry = cyc + 1;
                if (nxt == S_REQ && m_rc < 255) m_rc++;
                if (nxt == S_UP) begin m_widx = 0; m_werr = 0; end
            end
            m_state = nxt;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state", st, m_state);
        chk("reset_req", req, m_state == S_REQ);
        chk("link_ok", ok, m_state == S_UP);
        chk("reset_count", rc, m_rc);
        chk("soft_err_count", sec, m_sec);
    endtask

    task automatic wait_state(input int target, input int budget, input string tag, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            n++;
            if (st == target) found = 1'b1;
        end
        chk({tag, "_reached"}, found, 1);
    endtask

    task automatic measure_pulse(output int n);
        n = 0;
        for (int i = 0; i < 100 && req === 1'b1; i++) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n, up_at;
        int pos[3];
        longint kk, widx, woff, last_w;

        rst = 1; en = 1; frc = 0; cu = 0; lu = 0; he = 0; se = 0;
        tick(); tick();
        chk("rst_state", st, S_WAIT);
        chk("rst_req", req, 0);
        chk("rst_count", rc, 0);
        chk("rst_soft", sec, 0);
        rst = 0;

        up_at = -1;
        for (int i = 0; i < 40; i++) begin
            cu = (i >= 5); lu = (i >= 5);
            tick();
            if (ok === 1'b1 && up_at < 0) up_at = i;
        end
        chk("bringup_cycle", up_at, 5 + P_DEB - 1);

        cu = 0; tick(); cu = 1;
        chk("drop_req", req, 1);
        measure_pulse(n);
        chk("drop_pulse_len", n, P_REQ);
        chk("drop_count", rc, 1);
        wait_state(S_UP, 400, "reup", n);
        chk("reup_cycles", n, P_HOLD + P_DEB);

        en = 0; cu = 0; tick(); cu = 1;
        chk("drop_noen_state", st, S_WAIT);
        chk("drop_noen_req", req, 0);
        chk("drop_noen_count", rc, 1);
        wait_state(S_UP, 40, "reup2", n);
        chk("reup2_cycles", n, P_DEB);
        en = 1;

        last_w = -1;
        for (int i = 0; i < 5 * P_WIN; i++) begin
            kk = cyc - m_entry; widx = (kk + 1) / P_WIN; woff = (kk + 1) % P_WIN;
            if (widx != last_w) begin
                last_w = widx;
                pos[0] = $urandom_range(1, 332);
                pos[1] = $urandom_range(333, 665);
                pos[2] = $urandom_range(666, 999);
            end
            se = (woff == pos[0]) || (woff == pos[1]) || (woff == pos[2]);
            tick();
        end
        se = 0;
        chk("soft_15_count", sec, 15);
        chk("soft_15_state", st, S_UP);
        chk("soft_15_resets", rc, 1);
        for (int i = 0; i < 60; i++) begin
            kk = cyc - m_entry; woff = (kk + 1) % P_WIN;
            se = (woff > 0) && (woff <= 40) && (woff % 10 == 0);
            tick();
            if (woff == 40) chk("soft_limit_req", st, S_REQ);
        end
        se = 0;
        chk("soft_limit_count", rc, 2);

        cu = 0; lu = 0;
        wait_state(S_WAIT, 400, "to_wait", n);
        wait_state(S_REQ, 200, "to_req", n);
        chk("timeout_cycles", n, P_UP_TIMEOUT);
        chk("timeout_count1", rc, 3);
        measure_pulse(n);
        chk("timeout_pulse1", n, P_REQ);
        wait_state(S_REQ, 600, "to_req2", n);
        chk("timeout_cycles2", n, P_HOLD + P_UP_TIMEOUT);
        chk("timeout_count2", rc, 4);
        measure_pulse(n);
        chk("timeout_pulse2", n, P_REQ);

        wait_state(S_WAIT, 400, "sat_wait", n);
        en = 0;
        repeat (150) tick();
        chk("noen_sat_state", st, S_WAIT);
        en = 1; tick();
        chk("late_enable", st, S_REQ);

        n = 0;
        for (int i = 0; i < 100 && req === 1'b1; i++) begin
            frc = (n == 5) || (n == 10);
            n++;
            tick();
        end
        frc = 0;
        chk("force_in_req_len", n, P_REQ);
        chk("force_in_req_count", rc, 5);
        repeat (10) tick();
        frc = 1; tick(); frc = 0;
        chk("force_in_holdoff", st, S_REQ);
        chk("force_in_holdoff_count", rc, 6);

        repeat (5) tick();
        rst = 1; tick(); rst = 0;
        chk("rst_mid_req", req, 0);
        chk("rst_mid_count", rc, 0);
        chk("rst_mid_state", st, S_WAIT);

        for (int k = 0; k < 300; k++) begin
            frc = 1; tick(); frc = 0;
            wait_state(S_HOLD, 40, "sat_hold", n);
        end
        chk("reset_count_sat", rc, 255);

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 7) != 0);
            frc = ($urandom_range(0, 149) == 0);
            cu  = ($urandom_range(0, 199) != 0);
            lu  = ($urandom_range(0, 199) != 0);
            he  = ($urandom_range(0, 299) == 0);
            se  = ($urandom_range(0, 19) == 0);
            tick();
        end
        frc = 0; he = 0; se = 0;

        rst = 1; tick(); rst = 0;
        en = 0; cu = 1; lu = 1;
        wait_state(S_UP, 40, "sat_up", n);
        se = 1;
        repeat (65600) tick();
        se = 0;
        chk("soft_count_sat", sec, 65535);
        chk("soft_sat_state", st, S_UP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
